// File: rtl/tetris_pkg.sv
// Shared constants for the Tetris pixel renderer: piece codes, colours, region codes,
// the per-pixel pipeline payload and the piece colour/shape lookups.
package tetris_pkg;

  localparam logic [2:0] PIECE_NONE = 3'd0;
  localparam logic [2:0] PIECE_I    = 3'd1;
  localparam logic [2:0] PIECE_T    = 3'd2;
  localparam logic [2:0] PIECE_O    = 3'd3;
  localparam logic [2:0] PIECE_L    = 3'd4;
  localparam logic [2:0] PIECE_J    = 3'd5;
  localparam logic [2:0] PIECE_S    = 3'd6;
  localparam logic [2:0] PIECE_Z    = 3'd7;

  localparam logic [1:0] REG_BG      = 2'd0;
  localparam logic [1:0] REG_BOARD   = 2'd1;
  localparam logic [1:0] REG_FRAME   = 2'd2;
  localparam logic [1:0] REG_PREVIEW = 2'd3;

  localparam int CELL_IDX_W = 5;
  localparam int SUB_W      = 5;

  localparam logic [23:0] LIGHT_ROSE = 24'hFFCCE5;
  localparam logic [23:0] PURPLE     = 24'h9933FF;
  localparam logic [23:0] LIGHT_GREY = 24'hC0C0C0;
  localparam logic [23:0] DARK_GREY  = 24'h404040;
  localparam logic [23:0] WHITE      = 24'hFFFFFF;
  localparam logic [23:0] COL_I      = 24'h00FFFF;
  localparam logic [23:0] COL_T      = 24'h66B2FF;
  localparam logic [23:0] COL_O      = 24'hFF3399;
  localparam logic [23:0] COL_L      = 24'hFF9933;
  localparam logic [23:0] COL_J      = 24'hFFFF66;
  localparam logic [23:0] COL_S      = 24'h66FF66;
  localparam logic [23:0] COL_Z      = 24'hFF3333;

  typedef struct packed {
    logic [1:0] region;
    logic       blank_n;
    logic       shade;
    logic       flash;
    logic [2:0] prv_code;
  } pix_stage_t;

  function automatic logic [23:0] piece_color(input logic [2:0] code);
    logic [23:0] c;
    case (code)
      PIECE_I: c = COL_I;
      PIECE_T: c = COL_T;
      PIECE_O: c = COL_O;
      PIECE_L: c = COL_L;
      PIECE_J: c = COL_J;
      PIECE_S: c = COL_S;
      PIECE_Z: c = COL_Z;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Halves each 8-bit channel independently.
  function automatic logic [23:0] shade_color(input logic [23:0] c);
    return (c >> 1) & 24'h7F7F7F;
  endfunction

  // Mask bit index is {y, x}: bits 3:0 are the top row, bit 0 the leftmost cell.
  function automatic logic piece_shape(input logic [2:0] code, input logic [1:0] x, input logic y);
    logic [7:0] m;
    case (code)
      PIECE_I: m = 8'b0000_1111;
      PIECE_T: m = 8'b0010_0111;
      PIECE_O: m = 8'b0110_0110;
      PIECE_L: m = 8'b0001_0111;
      PIECE_J: m = 8'b0100_0111;
      PIECE_S: m = 8'b0011_0110;
      PIECE_Z: m = 8'b0110_0011;
      default: m = 8'b0000_0000;
    endcase
    return m[{y, x}];
  endfunction

endpackage

// File: rtl/cell_tracker.sv
// Sub-pixel / cell-index counter pair aligned to an origin pulse. Outputs are the
// next-state values so the caller registers them in the same stage as the pixel.
module cell_tracker
  import tetris_pkg::*;
#(
  parameter int CELL_PX = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  adv,
  output logic                  sub_zero,
  output logic [CELL_IDX_W-1:0] idx
);

  logic [SUB_W-1:0]      sub_q, sub_d;
  logic [CELL_IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (load) begin
      sub_d = '0;
      idx_d = '0;
    end else if (adv) begin
      if (sub_q == SUB_W'(CELL_PX - 1)) begin
        sub_d = '0;
        idx_d = idx_q + CELL_IDX_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

  assign sub_zero = (sub_d == '0);
  assign idx      = idx_d;

endmodule

// File: rtl/tetris_pixel_renderer.sv
// Two-clock pixel pipeline: S0 decodes region and board address, S1 meets the board
// RAM data, S2 registers the final colour for the DAC.
module tetris_pixel_renderer
  import tetris_pkg::*;
#(
  parameter int CELL_PX    = 20,
  parameter int BOARD_COLS = 10,
  parameter int BOARD_ROWS = 20,
  parameter int BOARD_X0   = 220,
  parameter int BOARD_Y0   = 40,
  parameter int FRAME_PX   = 20,
  parameter int NEXT_X0    = 480,
  parameter int NEXT_Y0    = 40,
  parameter int FLASH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blank_n,
  input  logic [8:0]            row,
  input  logic [9:0]            column,
  input  logic                  frame_start,
  output logic [7:0]            cell_addr,
  input  logic [2:0]            cell_data,
  input  logic [2:0]            next_piece,
  input  logic [BOARD_ROWS-1:0] flash_rows,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue
);

  localparam int FC_W = FLASH_LOG2 + 1;
  localparam int BW   = BOARD_COLS * CELL_PX;
  localparam int BH   = BOARD_ROWS * CELL_PX;
  localparam int NW   = 6 * CELL_PX;
  localparam int NH   = 4 * CELL_PX;

  localparam logic [9:0] BX0  = 10'(BOARD_X0);
  localparam logic [9:0] BX1  = 10'(BOARD_X0 + BW);
  localparam logic [9:0] BFX0 = 10'(BOARD_X0 - FRAME_PX);
  localparam logic [9:0] BFX1 = 10'(BOARD_X0 + BW + FRAME_PX);
  localparam logic [8:0] BY0  = 9'(BOARD_Y0);
  localparam logic [8:0] BY1  = 9'(BOARD_Y0 + BH);
  localparam logic [8:0] BFY0 = 9'(BOARD_Y0 - FRAME_PX);
  localparam logic [8:0] BFY1 = 9'(BOARD_Y0 + BH + FRAME_PX);
  localparam logic [9:0] NX0  = 10'(NEXT_X0);
  localparam logic [9:0] NX1  = 10'(NEXT_X0 + NW);
  localparam logic [9:0] NFX0 = 10'(NEXT_X0 - FRAME_PX);
  localparam logic [9:0] NFX1 = 10'(NEXT_X0 + NW + FRAME_PX);
  localparam logic [8:0] NY0  = 9'(NEXT_Y0);
  localparam logic [8:0] NY1  = 9'(NEXT_Y0 + NH);
  localparam logic [8:0] NFY0 = 9'(NEXT_Y0 - FRAME_PX);
  localparam logic [8:0] NFY1 = 9'(NEXT_Y0 + NH + FRAME_PX);

  pix_stage_t      s0_q, s0_d, s1_q, s1_d;
  logic [7:0]      cell_addr_q, cell_addr_d;
  logic [23:0]     rgb_q, rgb_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [8:0]      row_prev_q, row_prev_d;

  logic                  row_chg;
  logic                  bx_sub0, by_sub0, nx_sub0, ny_sub0;
  logic [CELL_IDX_W-1:0] cell_x, cell_y, prv_x, prv_y;
  logic                  unused_prv_sub;

  logic in_board, in_prev, in_frame, prv_hit, flash_hit;

  assign row_chg        = (row != row_prev_q);
  assign unused_prv_sub = nx_sub0 ^ ny_sub0;

  cell_tracker #(.CELL_PX(CELL_PX)) u_board_x (
    .clk(clk), .rst(rst), .load(column == BX0), .adv(1'b1),
    .sub_zero(bx_sub0), .idx(cell_x)
  );
  cell_tracker #(.CELL_PX(CELL_PX)) u_board_y (
    .clk(clk), .rst(rst), .load(row_chg && (row == BY0)), .adv(row_chg),
    .sub_zero(by_sub0), .idx(cell_y)
  );
  cell_tracker #(.CELL_PX(CELL_PX)) u_prev_x (
    .clk(clk), .rst(rst), .load(column == NX0), .adv(1'b1),
    .sub_zero(nx_sub0), .idx(prv_x)
  );
  cell_tracker #(.CELL_PX(CELL_PX)) u_prev_y (
    .clk(clk), .rst(rst), .load(row_chg && (row == NY0)), .adv(row_chg),
    .sub_zero(ny_sub0), .idx(prv_y)
  );

  always_comb begin
    in_board = (row >= BY0) && (row < BY1) && (column >= BX0) && (column < BX1);
    in_prev  = (row >= NY0) && (row < NY1) && (column >= NX0) && (column < NX1);
    // Frame bands are the outer rectangles minus their interiors, so they never overlap.
    in_frame = ((row >= BFY0) && (row < BFY1) && (column >= BFX0) && (column < BFX1) && !in_board)
            || ((row >= NFY0) && (row < NFY1) && (column >= NFX0) && (column < NFX1) && !in_prev);

    flash_hit = (cell_y < CELL_IDX_W'(BOARD_ROWS)) ? flash_rows[cell_y] : 1'b0;
    prv_hit   = (prv_x >= CELL_IDX_W'(1)) && (prv_x <= CELL_IDX_W'(4))
             && (prv_y >= CELL_IDX_W'(1)) && (prv_y <= CELL_IDX_W'(2))
             && piece_shape(next_piece, prv_x[1:0] - 2'd1, prv_y[1]);

    s0_d          = '0;
    s0_d.blank_n  = blank_n;
    s0_d.shade    = bx_sub0 | by_sub0;
    s0_d.flash    = flash_hit & frame_cnt_q[FLASH_LOG2];
    s0_d.prv_code = prv_hit ? next_piece : PIECE_NONE;
    if (in_board)      s0_d.region = REG_BOARD;
    else if (in_frame) s0_d.region = REG_FRAME;
    else if (in_prev)  s0_d.region = REG_PREVIEW;
    else               s0_d.region = REG_BG;

    cell_addr_d = in_board ? 8'(cell_y * BOARD_COLS + cell_x) : cell_addr_q;
    frame_cnt_d = frame_start ? frame_cnt_q + FC_W'(1) : frame_cnt_q;
    row_prev_d  = row;
    s1_d        = s0_q;

    case (s1_q.region)
      REG_BOARD: begin
        if (cell_data == PIECE_NONE) rgb_d = LIGHT_ROSE;
        else if (s1_q.flash)         rgb_d = WHITE;
        else if (s1_q.shade)         rgb_d = shade_color(piece_color(cell_data));
        else                         rgb_d = piece_color(cell_data);
      end
      REG_FRAME:   rgb_d = LIGHT_GREY;
      REG_PREVIEW: rgb_d = (s1_q.prv_code != PIECE_NONE) ? piece_color(s1_q.prv_code) : PURPLE;
      default:     rgb_d = DARK_GREY;
    endcase
    if (!s1_q.blank_n) rgb_d = 24'h000000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q        <= '0;
      s1_q        <= '0;
      cell_addr_q <= '0;
      rgb_q       <= '0;
      frame_cnt_q <= '0;
      row_prev_q  <= '0;
    end else begin
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      cell_addr_q <= cell_addr_d;
      rgb_q       <= rgb_d;
      frame_cnt_q <= frame_cnt_d;
      row_prev_q  <= row_prev_d;
    end
  end

  assign cell_addr = cell_addr_q;
  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];

endmodule

// File: tb/tb_tetris_pixel_renderer.sv
// Directed bench for tetris_pixel_renderer: drives scan lines and checks colours
// and board addresses against hand-derived values.
module tb_tetris_pixel_renderer;
  import tetris_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        blank_n;
  logic [8:0]  row;
  logic [9:0]  column;
  logic        frame_start;
  logic [7:0]  cell_addr;
  logic [2:0]  cell_data = 3'd0;
  logic [2:0]  next_piece;
  logic [19:0] flash_rows;
  logic [7:0]  red, green, blue;
  logic [2:0]  ram_code = 3'd0;

  int n_asserts = 0;
  int n_fail    = 0;

  tetris_pixel_renderer dut (
    .clk(clk), .rst(rst), .blank_n(blank_n), .row(row), .column(column),
    .frame_start(frame_start), .cell_addr(cell_addr), .cell_data(cell_data),
    .next_piece(next_piece), .flash_rows(flash_rows),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // Board RAM: only cell 3 (row 0, column 3) is occupied.
  always @(posedge clk) cell_data <= (cell_addr == 8'd3) ? ram_code : 3'd0;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic px(input int r, input int c, input logic b, input logic fs);
    row = 9'(r); column = 10'(c); blank_n = b; frame_start = fs;
    @(posedge clk); #1;
  endtask

  function automatic logic [23:0] exp_px(input int r, input int c, input int wf);
    if (r >= 40 && r < 440 && c >= 220 && c < 420) begin
      if (r < 60 && c >= 280 && c < 300) begin
        if (c >= wf)  return WHITE;
        if (c == 280) return 24'h33597F;
        return 24'h66B2FF;
      end
      return 24'hFFCCE5;
    end
    if (r >= 40 && r < 120 && c >= 480 && c < 600)
      return (next_piece == 3'd3 && r >= 60 && r < 100 && c >= 520 && c < 560) ? 24'hFF3399 : PURPLE;
    if ((r >= 20 && r < 460 && c >= 200 && c < 440) || (r >= 20 && r < 140 && c >= 460 && c < 620))
      return LIGHT_GREY;
    return DARK_GREY;
  endfunction

  // Sweep one line; wf is the first column that shows the flash (large = never).
  task automatic sweep(input int r, input int c0, input int c1, input int blank_col,
                       input int fs_col, input int wf);
    logic [23:0] exq[$];
    for (int c = c0; c <= c1; c++) begin
      exq.push_back((c == blank_col) ? 24'h000000 : exp_px(r, c, wf));
      px(r, c, c != blank_col, c == fs_col);
      if (r == 45 && c >= 220 && c < 440)
        chk($sformatf("addr c%0d", c), {16'h0, cell_addr}, 24'((c < 420) ? (c - 220) / 20 : 9));
      if (c >= c0 + 2)
        chk($sformatf("rgb r%0d c%0d", r, c - 2), {red, green, blue}, exq.pop_front());
    end
  endtask

  task automatic probe(input int r, input int c, input logic [23:0] exp);
    repeat (3) px(r, c, 1'b1, 1'b0);
    chk($sformatf("probe r%0d c%0d", r, c), {red, green, blue}, exp);
  endtask

  initial begin
    rst = 1'b1; row = 9'd50; column = 10'd230; blank_n = 1'b1;
    frame_start = 1'b0; next_piece = 3'd0; flash_rows = 20'h0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rgb in reset", {red, green, blue}, 24'h000000);
    end
    chk("addr after reset", {16'h0, cell_addr}, 24'h000000);
    rst = 1'b0;
    px(50, 230, 1'b1, 1'b0); chk("rgb rel+1", {red, green, blue}, 24'h000000);
    px(50, 230, 1'b1, 1'b0); chk("rgb rel+2", {red, green, blue}, 24'h000000);
    px(50, 230, 1'b1, 1'b0); chk("rgb rel+3", {red, green, blue}, 24'hFFCCE5);

    ram_code = 3'd2;
    for (int r = 39; r <= 45; r++) px(r, 0, 1'b1, 1'b0);
    sweep(45, 200, 445, 300, -1, 1000);

    flash_rows = 20'h00001;
    repeat (15) px(45, 0, 1'b1, 1'b1);
    sweep(45, 215, 300, -1, 285, 286);
    repeat (15) px(45, 0, 1'b1, 1'b1);
    sweep(45, 215, 300, -1, -1, 0);
    px(45, 0, 1'b1, 1'b1);
    sweep(45, 215, 300, -1, -1, 1000);

    for (int r = 46; r <= 70; r++) px(r, 0, 1'b1, 1'b0);
    next_piece = 3'd3;
    sweep(70, 475, 585, -1, -1, 1000);
    next_piece = 3'd0;
    sweep(70, 475, 585, -1, -1, 1000);
    next_piece = 3'd3;
    for (int r = 71; r <= 100; r++) px(r, 0, 1'b1, 1'b0);
    sweep(100, 475, 585, -1, -1, 1000);

    px(100, 250, 1'b1, 1'b0);
    px(100, 251, 1'b1, 1'b0);
    rst = 1'b1;
    px(100, 252, 1'b1, 1'b0);
    chk("rgb mid-line reset", {red, green, blue}, 24'h000000);
    rst = 1'b0;

    probe(25, 300, LIGHT_GREY);
    probe(300, 210, LIGHT_GREY);
    probe(130, 500, LIGHT_GREY);
    probe(470, 10, DARK_GREY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_pixel_renderer.md
Name: tetris_pixel_renderer

Overview:
- Pipelined, parametrised successor to the static playfield colouriser.
- Draws the frame, the background, the occupied board cells from an external synchronous board RAM, a next-piece preview and a flash effect on rows being cleared.
- Sits between the VGA timing generator and the DAC: it takes the row/column/blank_n stream and returns 8-bit RGB two clocks later.

Parameters:
- CELL_PX, 20, cell edge length in pixels
- BOARD_COLS, 10, board width in cells
- BOARD_ROWS, 20, board height in cells
- BOARD_X0, 220, first board pixel column
- BOARD_Y0, 40, first board pixel row
- FRAME_PX, 20, frame thickness around the board and the preview field
- NEXT_X0, 480, first preview pixel column; the preview is 6x4 cells
- NEXT_Y0, 40, first preview pixel row
- FLASH_LOG2, 4, flash half-period equals 2^FLASH_LOG2 frames

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- blank_n  in  1  high during the visible area
- row  in  9  current pixel row
- column  in  10  current pixel column; increments by 1 per clk within a line
- frame_start  in  1  one-cycle pulse at the first pixel of each frame
- cell_addr  out  8  board RAM address, cell_y*BOARD_COLS+cell_x
- cell_data  in  3  RAM data, valid 1 clk after cell_addr; 0 = empty, 1..7 = I,T,O,L,J,S,Z
- next_piece  in  3  preview piece code, 0 = none
- flash_rows  in  BOARD_ROWS  bit r high marks board row r as clearing
- red  out  8  red channel
- green  out  8  green channel
- blue  out  8  blue channel

Behaviour:
- Reset: red/green/blue, cell_addr, every pipeline register, the cell counters and frame_cnt all go to 0.
- Latency: exactly 2 clk from row/column/blank_n to RGB.
  - S0 registers the region code, cell_addr, the sub-pixel flags and blank_n.
  - S1 receives cell_data; the region code and blank_n travel with it.
  - S2 registers the colour.
  - blank_n after the delay low: RGB = 0.
- Cell tracking uses counters, no dividers.
  - col_sub/cell_x load 0 when column == BOARD_X0.
  - col_sub increments each clk; when it reaches CELL_PX-1 it wraps to 0 and cell_x increments.
  - Row side: row_sub/cell_y load 0 on the first clk with row == BOARD_Y0. On each row change, detected against a registered previous row, row_sub advances with the same wrap rule into cell_y.
  - Preview counters work the same way from NEXT_X0/NEXT_Y0.
- Regions are mutually exclusive; if they ever overlap, priority is board > frame > preview > background.
  - frame: FRAME_PX bands surrounding the board and the preview field.
- Colours:
  - Board, empty cell: LIGHT_ROSE.
  - Board, occupied cell: the piece colour from the package LUT. Where col_sub == 0 or row_sub == 0, use the grid-shaded colour (each channel >>1).
  - Board flash: when flash_rows[cell_y] && frame_cnt[FLASH_LOG2] and the cell is occupied, draw WHITE. Empty cells are unaffected.
  - Frame: LIGHT_GREY.
  - Preview: PURPLE by default. Cells (1..4, 1..2) where the package shape ROM bit for next_piece is set take that piece's colour. next_piece == 0 gives the whole field PURPLE.
  - Anything else: DARK_GREY.
- frame_cnt: FLASH_LOG2+1 bits, increments on frame_start and wraps naturally.
- frame_start coinciding with a board pixel: the new frame_cnt value applies from the next clk.
- cell_addr outside the board holds its last value; cell_data is then ignored.
- flash_rows changing mid-frame takes effect from the next pixel; no sampling is required.
- rst mid-line: outputs are 0 on the next clk. Counters resynchronise at the next BOARD_X0/BOARD_Y0 crossing.

Decomposition:
- Package tetris_pkg holds:
  - the piece code constants;
  - the 24-bit colour localparams (LIGHT_ROSE, PURPLE, LIGHT_GREY, DARK_GREY, WHITE and the seven piece colours);
  - the function piece_color(code);
  - the 4x2 shape ROM function piece_shape(code, x, y);
  - the region code constants.
- One sub-module, cell_tracker: an origin/CELL_PX counter pair producing sub and cell index. It is instantiated for board-x, board-y, preview-x and preview-y.

Test Plan:
- rst high for 3 clk with row=50, column=230, blank_n=1: RGB = 0 during reset and for 2 clk after release; afterwards LIGHT_ROSE (255,204,229) with cell_data=0.
- Full line on row 45, cell_data returns 2 when cell_addr==3: cell_addr steps 0..9 every 20 clk starting 1 clk after column 220. Columns 280..299 output BLUE (102,178,255), except column 280 shaded (51,89,127), all 2 clk late.
- blank_n toggled low for 1 clk at column 300: exactly one RGB=0 pixel appears at the 2-clk-delayed position.
- flash_rows[0]=1, cell occupied, 16 frame_start pulses applied: row-0 occupied cells are WHITE in frames 16..31 and the piece colour in frames 0..15. Empty cells stay LIGHT_ROSE.
- next_piece=3 (O): preview cells (2..3, 1..2) are PINK (255,51,153) and the rest PURPLE. next_piece=0: the whole field is PURPLE.
- Probes at (row,col) = (25,300), (300,210), (130,500), (470,10): outputs LIGHT_GREY, LIGHT_GREY, LIGHT_GREY and DARK_GREY respectively.
